// File: rtl/ysyx_22040127_mul_pkg.sv
// Shared encodings for the RV64M multiply controller: op codes, FSM states and core latency.
package ysyx_22040127_mul_pkg;

    localparam logic [2:0] MUL_OP_MUL    = 3'd0;
    localparam logic [2:0] MUL_OP_MULH   = 3'd1;
    localparam logic [2:0] MUL_OP_MULHSU = 3'd2;
    localparam logic [2:0] MUL_OP_MULHU  = 3'd3;
    localparam logic [2:0] MUL_OP_MULW   = 3'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Clock edges from the edge that raises mul_type to the edge that samples mul_ok.
    localparam int MUL_CORE_LAT = 2;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= MUL_OP_MULW;
    endfunction

endpackage

// File: rtl/ysyx_22040127_mul_sel.sv
// Combinational rd select from the 128-bit product, with MULW sign extension of the low word.
module ysyx_22040127_mul_sel
    import ysyx_22040127_mul_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_high,
    input  logic [XLEN-1:0] i_low,
    output logic [XLEN-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            MUL_OP_MUL:    o_result = i_low;
            MUL_OP_MULH,
            MUL_OP_MULHSU,
            MUL_OP_MULHU:  o_result = i_high;
            MUL_OP_MULW:   o_result = {{(XLEN-32){i_low[31]}}, i_low[31:0]};
            default:       o_result = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22040127_mul_ctrl.sv
// Issue/retire controller for the Booth/Wallace multiplier core.
// Optional build macro YSYX_22040127_MUL_ZERO_BYPASS_EN skips the core when either operand is zero.
module ysyx_22040127_mul_ctrl
    import ysyx_22040127_mul_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic [XLEN-1:0]  mul_x,
    output logic [XLEN-1:0]  mul_y,
    output logic             mul_xs,
    output logic             mul_ys,
    output logic             mul_type,
    input  logic [XLEN-1:0]  mul_high,
    input  logic [XLEN-1:0]  mul_low,
    input  logic             mul_ok,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       dbg_state
);

    // Handshakes: a request transfers on a rising edge where in_valid && in_ready;
    // a result transfers on a rising edge where out_valid && out_ready && !flush.
    logic [1:0]       r_state;
    logic [2:0]       r_op;
    logic [TAG_W-1:0] r_tag;
    logic [XLEN-1:0]  r_x;
    logic [XLEN-1:0]  r_y;
    logic             r_xs;
    logic             r_ys;
    logic             r_mul_type;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_result;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_zero_bypass;
    logic             w_skip_core;
    logic [XLEN-1:0]  w_sel_result;

    assign w_in_ready = (r_state == ST_IDLE) && !flush;
    assign w_accept   = in_valid && w_in_ready;

`ifdef YSYX_22040127_MUL_ZERO_BYPASS_EN
    assign w_zero_bypass = (in_src1 == '0) || (in_src2 == '0);
`else
    assign w_zero_bypass = 1'b0;
`endif

    // Reserved ops and zero-operand bypass both retire a zero without touching the core.
    assign w_skip_core = !op_is_legal(in_op) || w_zero_bypass;

    ysyx_22040127_mul_sel #(.XLEN(XLEN)) u_sel (
        .i_op     (r_op),
        .i_high   (mul_high),
        .i_low    (mul_low),
        .o_result (w_sel_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_op        <= MUL_OP_MUL;
            r_tag       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_xs        <= 1'b0;
            r_ys        <= 1'b0;
            r_mul_type  <= 1'b0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            r_mul_type <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= in_op;
                        r_tag <= in_tag;
                        r_x   <= in_src1;
                        r_y   <= in_src2;
                        r_xs  <= (in_op != MUL_OP_MULHU);
                        r_ys  <= (in_op == MUL_OP_MUL) || (in_op == MUL_OP_MULH) ||
                                 (in_op == MUL_OP_MULW);
                        if (w_skip_core) begin
                            r_result    <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_mul_type  <= 1'b1;
                            r_state     <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    // The core cannot be cancelled, so a flush must still wait out mul_ok.
                    if (flush) begin
                        r_state <= mul_ok ? ST_IDLE : ST_DRAIN;
                    end else if (mul_ok) begin
                        r_result    <= w_sel_result;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (flush || out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (mul_ok) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign mul_x      = r_x;
    assign mul_y      = r_y;
    assign mul_xs     = r_xs;
    assign mul_ys     = r_ys;
    assign mul_type   = r_mul_type;
    assign out_valid  = r_out_valid;
    assign out_result = r_result;
    assign out_tag    = r_tag;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_ysyx_22040127_mul_ctrl.sv
// Directed bench for the multiply controller with a behavioural multiplier core and result scoreboard.
module tb_ysyx_22040127_mul_ctrl;
    import ysyx_22040127_mul_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [63:0] in_src1;
    logic [63:0] in_src2;
    logic [3:0]  in_tag;
    logic        flush;
    logic [63:0] mul_x;
    logic [63:0] mul_y;
    logic        mul_xs;
    logic        mul_ys;
    logic        mul_type;
    logic [63:0] mul_high;
    logic [63:0] mul_low;
    logic        mul_ok;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [3:0]  out_tag;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int n_mt   = 0;
    int n_xfer = 0;

    logic [63:0] exp_q[$];
    logic [3:0]  tag_q[$];
    logic [63:0] exp_x;
    logic [63:0] exp_y;
    logic        exp_xs;
    logic        exp_ys;

    logic         core_ok   = 1'b0;
    logic         stray_ok  = 1'b0;
    logic [127:0] core_prod = '0;

    ysyx_22040127_mul_ctrl #(.XLEN(64), .TAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_tag     (in_tag),
        .flush      (flush),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_xs     (mul_xs),
        .mul_ys     (mul_ys),
        .mul_type   (mul_type),
        .mul_high   (mul_high),
        .mul_low    (mul_low),
        .mul_ok     (mul_ok),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] sx(input logic [63:0] v, input logic s);
        return {{64{s & v[63]}}, v};
    endfunction

    // Behavioural core: product of the operands seen with mul_type, mul_ok one cycle later.
    always @(posedge clk) begin
        core_ok <= mul_type;
        if (mul_type) core_prod <= sx(mul_x, mul_xs) * sx(mul_y, mul_ys);
    end
    assign mul_ok   = core_ok | stray_ok;
    assign mul_high = core_prod[127:64];
    assign mul_low  = core_prod[63:0];

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a,
                                               input logic [63:0] b);
        logic [127:0] p;
        p = '0;
        case (op)
            3'd0: begin p = sx(a, 1'b0) * sx(b, 1'b0); return p[63:0];   end
            3'd1: begin p = sx(a, 1'b1) * sx(b, 1'b1); return p[127:64]; end
            3'd2: begin p = sx(a, 1'b1) * sx(b, 1'b0); return p[127:64]; end
            3'd3: begin p = sx(a, 1'b0) * sx(b, 1'b0); return p[127:64]; end
            3'd4: begin p = sx(a, 1'b0) * sx(b, 1'b0); return {{32{p[31]}}, p[31:0]}; end
            default: return 64'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard / compare process
    always @(negedge clk) begin
        if (rst) begin
            if (mul_type) begin
                n_mt++;
                check("issue_x", mul_x, exp_x);
                check("issue_y", mul_y, exp_y);
                check("issue_xs", {63'd0, mul_xs}, {63'd0, exp_xs});
                check("issue_ys", {63'd0, mul_ys}, {63'd0, exp_ys});
            end
            if (out_valid) begin
                check("done_in_ready", {63'd0, in_ready}, 64'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
                end else begin
                    check("out_result", out_result, exp_q[0]);
                    check("out_tag", {60'd0, out_tag}, {60'd0, tag_q[0]});
                    if (flush || out_ready) begin
                        void'(exp_q.pop_front());
                        void'(tag_q.pop_front());
                        if (!flush) n_xfer++;
                    end
                end
            end
        end
    end

    // driver tasks: entered and left at posedge+2
    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] tag, input bit expect_out);
        int n;
        exp_x  = a;
        exp_y  = b;
        exp_xs = (op != 3'd3);
        exp_ys = (op == 3'd0) || (op == 3'd1) || (op == 3'd4);
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_tag   = tag;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", {63'd0, in_ready}, 64'd1);
        end else if (expect_out) begin
            exp_q.push_back(ref_result(op, a, b));
            tag_q.push_back(tag);
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] tag, input int exp_lat, input int exp_mt,
                          input logic [63:0] lit);
        int lat;
        int mt0;
        mt0 = n_mt;
        issue(op, a, b, tag, 1'b1);
        wait_valid(lat);
        check("latency", lat, exp_lat);
        check("result_literal", out_result, lit);
        @(posedge clk);
        #2;
        check("mul_type_pulses", n_mt - mt0, exp_mt);
        @(negedge clk);
        check("in_ready_after_xfer", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #2;
    endtask

    initial begin
        int lat;
        int x0;
        int mt0;
        logic [63:0] ta [4];
        logic [63:0] tb [4];
        logic [2:0]  to [4];

        rst = 1'b0; in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0; in_tag = '0;
        flush = 1'b0; out_ready = 1'b1;
        exp_x = '0; exp_y = '0; exp_xs = 1'b0; exp_ys = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mul_type", {63'd0, mul_type}, 64'd0);
        check("rst_mul_x", mul_x, 64'd0);
        check("rst_mul_y", mul_y, 64'd0);
        check("rst_xs_ys", {62'd0, mul_xs, mul_ys}, 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_tag", {60'd0, out_tag}, 64'd0);
        @(posedge clk); #2; rst = 1'b1;
        @(posedge clk); #2;

        run_op(MUL_OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'h1, MUL_CORE_LAT + 1, 1, 64'h1);
        run_op(MUL_OP_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'h2,
               MUL_CORE_LAT + 1, 1, 64'h0);
        run_op(MUL_OP_MUL,    64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'h3,
               MUL_CORE_LAT + 1, 1, 64'h1);
        run_op(MUL_OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 4'h4,
               MUL_CORE_LAT + 1, 1, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(MUL_OP_MULW,   64'h0000_0000_8000_0000, 64'd1, 4'h5,
               MUL_CORE_LAT + 1, 1, 64'hFFFF_FFFF_8000_0000);
        run_op(MUL_OP_MULW,   64'h0000_0000_7FFF_FFFF, 64'd2, 4'h6,
               MUL_CORE_LAT + 1, 1, 64'hFFFF_FFFF_FFFF_FFFE);

        ta[0] = 64'h1234_5678_9ABC_DEF0; tb[0] = 64'h0FED_CBA9_8765_4321; to[0] = MUL_OP_MUL;
        ta[1] = 64'h8000_0000_0000_0000; tb[1] = 64'h0000_0000_0000_0003; to[1] = MUL_OP_MULH;
        ta[2] = 64'h8000_0000_0000_0000; tb[2] = 64'h8000_0000_0000_0000; to[2] = MUL_OP_MULHSU;
        ta[3] = 64'hDEAD_BEEF_0000_FFFF; tb[3] = 64'hFFFF_FFFF_0001_0001; to[3] = MUL_OP_MULHU;
        for (int i = 0; i < 4; i++)
            run_op(to[i], ta[i], tb[i], 4'(i + 8), MUL_CORE_LAT + 1, 1, ref_result(to[i], ta[i], tb[i]));

        run_op(3'd5, 64'd7, 64'd9, 4'hC, 1, 0, 64'd0);
`ifdef YSYX_22040127_MUL_ZERO_BYPASS_EN
        run_op(MUL_OP_MUL, 64'd0, 64'h1234, 4'hD, 1, 0, 64'd0);
        run_op(MUL_OP_MULW, 64'h55, 64'd0, 4'hD, 1, 0, 64'd0);
`else
        run_op(MUL_OP_MUL, 64'd0, 64'h1234, 4'hD, MUL_CORE_LAT + 1, 1, 64'd0);
        run_op(MUL_OP_MULW, 64'h55, 64'd0, 4'hD, MUL_CORE_LAT + 1, 1, 64'd0);
`endif

        // back-pressure: result and tag held while out_ready is low
        out_ready = 1'b0;
        issue(MUL_OP_MUL, 64'd3, 64'd5, 4'h7, 1'b1);
        wait_valid(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            check("hold_result", out_result, 64'd15);
            check("hold_tag", {60'd0, out_tag}, 64'd7);
        end
        @(posedge clk); #2; out_ready = 1'b1; x0 = n_xfer;
        @(posedge clk); #2;
        @(negedge clk);
        check("release_out_valid", {63'd0, out_valid}, 64'd0);
        check("release_in_ready", {63'd0, in_ready}, 64'd1);
        check("release_xfer_count", n_xfer - x0, 64'd1);
        @(posedge clk); #2;

        // flush on the mul_type cycle: drain, then idle the cycle after mul_ok
        issue(MUL_OP_MUL, 64'd7, 64'd9, 4'h2, 1'b0);
        flush = 1'b1;
        @(posedge clk); #2; flush = 1'b0;
        @(negedge clk);
        check("drain_state", {62'd0, dbg_state}, {62'd0, ST_DRAIN});
        check("drain_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #2;
        @(negedge clk);
        check("drain_in_ready_back", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #2;

        // flush together with mul_ok
        issue(MUL_OP_MULH, 64'd7, 64'd9, 4'h3, 1'b0);
        @(posedge clk); #2; flush = 1'b1;
        @(negedge clk);
        check("flush_ok_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #2; flush = 1'b0;
        @(negedge clk);
        check("flush_ok_in_ready_back", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #2;

        // flush beats out_ready in DONE
        out_ready = 1'b0;
        issue(MUL_OP_MUL, 64'd2, 64'd3, 4'h9, 1'b1);
        wait_valid(lat);
        @(posedge clk); #2; flush = 1'b1; out_ready = 1'b1; x0 = n_xfer;
        @(posedge clk); #2; flush = 1'b0;
        @(negedge clk);
        check("done_flush_out_valid", {63'd0, out_valid}, 64'd0);
        check("done_flush_in_ready", {63'd0, in_ready}, 64'd1);
        check("done_flush_no_xfer", n_xfer - x0, 64'd0);
        @(posedge clk); #2;

        // flush in IDLE blocks a same-cycle request
        mt0 = n_mt;
        flush = 1'b1; in_valid = 1'b1; in_op = MUL_OP_MUL; in_src1 = 64'd4; in_src2 = 64'd4;
        @(negedge clk);
        check("idle_flush_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #2; flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("idle_flush_no_issue", n_mt - mt0, 64'd0);
        check("idle_flush_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
        @(posedge clk); #2;

        // reset mid-operation, then a stray mul_ok in IDLE
        issue(MUL_OP_MUL, 64'd11, 64'd13, 4'h4, 1'b0);
        @(posedge clk); #2; rst = 1'b0;
        #1;
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #2; rst = 1'b1; stray_ok = 1'b1;
        @(posedge clk); #2; stray_ok = 1'b0;
        @(negedge clk);
        check("stray_ok_out_valid", {63'd0, out_valid}, 64'd0);
        check("stray_ok_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #2;
        run_op(MUL_OP_MUL, 64'd6, 64'd7, 4'h5, MUL_CORE_LAT + 1, 1, 64'd42);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
